tx8b10b_sched: RTL and testbench
================================

// Module: tx8b10b_sched
// PURPOSE
//  Transmit character scheduler in front of the 8b/10b encoder (k/eb inputs). Takes a
//  byte stream with valid/ready/last from the link layer and emits one character per
//  clk: comma alignment after reset, K28.5 idles, SOF/EOF framing, underrun fill and
//  optional clock-compensation skips. Sole driver of the encoder's k and eb inputs.
// PARAMETERS
//  ALIGN_CNT      16    K28.5 chars sent after reset or retrain before IDLE is entered
//  IFG_MIN        2     min idle chars (K28.5 or K28.0) between EOF and next SOF
//  SKIP_INTERVAL  1024  clk cycles between skip requests (TX_SKIP_EN only)
//  SKIP_LEN       2     K28.0 chars per skip sequence (TX_SKIP_EN only)
//  CNT_W          16    width of fill_cnt / pkt_cnt
// PORTS
//  clk       in   1      clock
//  reset     in   1      synchronous, active-high reset
//  link_en   in   1      1 = link may carry packets; sampled in IDLE and ALIGN only
//  s_valid   in   1      upstream byte valid
//  s_data    in   8      upstream byte
//  s_last    in   1      s_data is last byte of packet
//  s_ready   out  1      byte accepted on posedge when s_valid & s_ready
//  enc_k     out  1      to encoder k
//  enc_eb    out  8      to encoder eb
//  busy      out  1      1 while in SOF..EOF (DATA state or EOF pending)
//  fill_cnt  out  CNT_W  count of K23.7 fill chars, saturates at all-ones
//  pkt_cnt   out  CNT_W  count of EOFs sent, wraps
// BEHAVIOUR
//  - enc_k/enc_eb registered; one char loaded every posedge. Byte accepted at edge N
//    is on enc_eb after edge N (latency 1 from accept to encoder input).
//  - Chars: COMMA K28.5=BC, SOF K27.7=FB, EOF K29.7=FD, FILL K23.7=F7, SKIP K28.0=1C.
//  - Reset: state ALIGN, align/ifg/skip counters 0, enc_k=1, enc_eb=BC, s_ready=0,
//    busy=0, fill_cnt=0, pkt_cnt=0. Reset mid-packet truncates it: no EOF sent.
//  - s_ready = (state==DATA); combinational from state only, never from s_valid.
//  - ALIGN: load COMMA each cycle, count; after ALIGN_CNT commas -> IDLE (if link_en=0
//    counter holds at 0, commas continue). ifg_cnt preset to IFG_MIN on exit.
//  - IDLE: priority (1) link_en=0 -> load COMMA, go ALIGN (retrain); (2) skip pending
//    -> go SKIP; (3) s_valid & ifg_cnt>=IFG_MIN -> load SOF, go DATA; (4) load COMMA,
//    ifg_cnt++ (saturating). s_data not consumed while loading SOF.
//  - DATA: s_valid -> load s_data, k=0; if s_last -> EOF. s_valid=0 -> load FILL
//    (k=1), fill_cnt++ sat, stay. link_en and skip requests ignored in DATA.
//  - EOF: load EOF char, pkt_cnt++, ifg_cnt=0, go IDLE. Back-to-back packets
//    therefore see exactly IFG_MIN commas between EOF and SOF.
//  - Zero-length packets impossible: first DATA beat always carries a byte or FILL.
//  - busy=1 in DATA and EOF states, 0 otherwise.
// CONFIGURATION
//  TX_SKIP_EN defined: free-running skip timer counts every cycle outside ALIGN; at
//   SKIP_INTERVAL-1 sets skip_pend (sticky; a second expiry while pending is dropped).
//   SKIP state loads SKIP char SKIP_LEN times, counts toward ifg_cnt, clears
//   skip_pend, returns to IDLE. Skip never splits a packet; deferred until IDLE.
//  TX_SKIP_EN undefined: no timer, no SKIP state, K28.0 never emitted; SKIP_INTERVAL
//   and SKIP_LEN unused.
// STRUCTURE
//  Package tx8b10b_pkg: char constants (K_COMMA, K_SOF, K_EOF, K_FILL, K_SKIP) and
//  state enum {ALIGN, IDLE, SKIP, DATA, EOF}. Sub-module tx8b10b_skip_timer (counter
//  + sticky pend, clear input) instantiated only under TX_SKIP_EN. Rest is one FSM
//  plus output register in this module.
// TESTING
//  1 reset 1 cycle, link_en=1, s_valid=0 -> 16 x (k=1,BC) then BC continuous, s_ready=0
//  2 after align, pkt A1,A2,A3(last) held valid -> FB,A1,A2,A3,FD; pkt_cnt=1; busy 5cyc
//  3 pkt 10,20(last) with s_valid low 2 cycles after 10 -> FB,10,F7,F7,20,FD; fill_cnt=2
//  4 two 1-byte pkts 55,66 back-to-back -> FB,55,FD,BC,BC,FB,66,FD (IFG_MIN=2)
//  5 reset asserted while in DATA after byte 77 -> next char BC, no FD, s_ready=0,
//    pkt_cnt=0, 16 commas before first SOF
//  6 TX_SKIP_EN, SKIP_INTERVAL=32, pkt spanning expiry -> 1C,1C only after FD+idle,
//    never inside packet; link_en=0 in IDLE -> ALIGN, 16 BC after link_en=1

Source files
------------

// File: rtl/tx8b10b_pkg.sv
// tx8b10b_pkg: character codes and FSM states shared by the 8b/10b transmit scheduler
package tx8b10b_pkg;

    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam logic [7:0] K_SOF   = 8'hFB;
    localparam logic [7:0] K_EOF   = 8'hFD;
    localparam logic [7:0] K_FILL  = 8'hF7;
    localparam logic [7:0] K_SKIP  = 8'h1C;

    typedef enum logic [2:0] {ALIGN, IDLE, SKIP, DATA, EOF} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tx8b10b_skip_timer.sv
// tx8b10b_skip_timer: free-running clock-compensation timer with a sticky skip request
module tx8b10b_skip_timer #(
    parameter int SKIP_INTERVAL = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic pend
);

    localparam int W = $clog2(SKIP_INTERVAL + 1);

    logic [W-1:0] cnt;
    logic         expire;

    assign expire = en && (cnt == W'(SKIP_INTERVAL - 1));

    // an expiry while a request is already pending merges into it
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            if (en)
                cnt <= expire ? '0 : cnt + W'(1);
            pend <= expire | (pend & ~clr);
        end
    end

endmodule

// File: rtl/tx8b10b_sched.sv
// tx8b10b_sched: per-clock character scheduler feeding the 8b/10b encoder k/eb inputs.
// Define TX_SKIP_EN to enable periodic K28.0 clock-compensation skip sequences.
module tx8b10b_sched
    import tx8b10b_pkg::*;
#(
    parameter int ALIGN_CNT     = 16,
    parameter int IFG_MIN       = 2,
    parameter int SKIP_INTERVAL = 1024,
    parameter int SKIP_LEN      = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             link_en,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             enc_k,
    output logic [7:0]       enc_eb,
    output logic             busy,
    output logic [CNT_W-1:0] fill_cnt,
    output logic [CNT_W-1:0] pkt_cnt
);

    state_t      state, state_n;
    logic [15:0] align_cnt, align_n;
    logic [7:0]  ifg_cnt, ifg_n;
    logic [7:0]  eb_n;
    logic        k_n, busy_n, fill_inc, pkt_inc, skip_pend;

`ifdef TX_SKIP_EN
    logic [7:0] skip_cnt, skip_n;
    logic       skip_clr;

    tx8b10b_skip_timer #(.SKIP_INTERVAL(SKIP_INTERVAL)) u_skip_timer (
        .clk   (clk),
        .reset (reset),
        .en    (state != ALIGN),
        .clr   (skip_clr),
        .pend  (skip_pend)
    );

    always_ff @(posedge clk) begin
        if (reset)
            skip_cnt <= '0;
        else
            skip_cnt <= skip_n;
    end
`else
    logic unused_skip_cfg;
    assign unused_skip_cfg = (SKIP_INTERVAL > 0) && (SKIP_LEN > 0);
    assign skip_pend       = 1'b0;
`endif

    assign s_ready = (state == DATA);

    always_comb begin
        state_n  = state;
        align_n  = align_cnt;
        ifg_n    = ifg_cnt;
        k_n      = 1'b1;
        eb_n     = K_COMMA;
        busy_n   = 1'b0;
        fill_inc = 1'b0;
        pkt_inc  = 1'b0;
`ifdef TX_SKIP_EN
        skip_n   = skip_cnt;
        skip_clr = 1'b0;
`endif
        case (state)
            ALIGN: begin
                if (!link_en) begin
                    align_n = '0;
                end else if (align_cnt == 16'(ALIGN_CNT - 1)) begin
                    align_n = '0;
                    ifg_n   = 8'(IFG_MIN);
                    state_n = IDLE;
                end else begin
                    align_n = align_cnt + 16'd1;
                end
            end
            IDLE: begin
                if (!link_en) begin
                    align_n = '0;
                    state_n = ALIGN;
                end else if (skip_pend) begin
                    ifg_n   = sat_inc8(ifg_cnt);
                    state_n = SKIP;
                end else if (s_valid && ifg_cnt >= 8'(IFG_MIN)) begin
                    eb_n    = K_SOF;
                    busy_n  = 1'b1;
                    state_n = DATA;
                end else begin
                    ifg_n = sat_inc8(ifg_cnt);
                end
            end
`ifdef TX_SKIP_EN
            SKIP: begin
                eb_n  = K_SKIP;
                ifg_n = sat_inc8(ifg_cnt);
                if (skip_cnt == 8'(SKIP_LEN - 1)) begin
                    skip_n   = '0;
                    skip_clr = 1'b1;
                    state_n  = IDLE;
                end else begin
                    skip_n = skip_cnt + 8'd1;
                end
            end
`endif
            DATA: begin
                busy_n = 1'b1;
                if (s_valid) begin
                    k_n  = 1'b0;
                    eb_n = s_data;
                    if (s_last)
                        state_n = EOF;
                end else begin
                    eb_n     = K_FILL;
                    fill_inc = 1'b1;
                end
            end
            EOF: begin
                busy_n  = 1'b1;
                eb_n    = K_EOF;
                pkt_inc = 1'b1;
                ifg_n   = '0;
                state_n = IDLE;
            end
            default: state_n = ALIGN;
        endcase
    end

    // busy is registered with the character so it covers SOF through EOF on the wire
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ALIGN;
            align_cnt <= '0;
            ifg_cnt   <= '0;
            enc_k     <= 1'b1;
            enc_eb    <= K_COMMA;
            busy      <= 1'b0;
            fill_cnt  <= '0;
            pkt_cnt   <= '0;
        end else begin
            state     <= state_n;
            align_cnt <= align_n;
            ifg_cnt   <= ifg_n;
            enc_k     <= k_n;
            enc_eb    <= eb_n;
            busy      <= busy_n;
            if (fill_inc && fill_cnt != '1)
                fill_cnt <= fill_cnt + CNT_W'(1);
            if (pkt_inc)
                pkt_cnt <= pkt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tx8b10b_sched.sv
// tb_tx8b10b_sched: directed self-checking bench for the 8b/10b transmit scheduler
module tb_tx8b10b_sched;
    import tx8b10b_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        link_en = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        s_ready, enc_k, busy;
    logic [7:0]  enc_eb;
    logic [15:0] fill_cnt, pkt_cnt;

    int checks = 0;
    int failures = 0;
    int sk_total = 0;
    int sk_in_pkt = 0;

    tx8b10b_sched #(.SKIP_INTERVAL(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .link_en  (link_en),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .enc_k    (enc_k),
        .enc_eb   (enc_eb),
        .busy     (busy),
        .fill_cnt (fill_cnt),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && enc_k && enc_eb == K_SKIP) begin
            sk_total++;
            if (busy)
                sk_in_pkt++;
        end
    end

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; link_en = 1'b1; s_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, s_ready, enc_k, enc_eb} !== {3'b001, K_COMMA}) begin
            failures++;
            $display("FAIL reset_out got busy=%0b rdy=%0b k=%0b eb=%02h want 0 0 1 bc", busy, s_ready, enc_k, enc_eb);
        end
        checks++;
        if (fill_cnt !== 16'd0 || pkt_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt got fill=%0d pkt=%0d want 0 0", fill_cnt, pkt_cnt);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, s_ready, enc_k, enc_eb} !== {3'b001, K_COMMA}) begin
                failures++;
                $display("FAIL align_comma[%0d] got busy=%0b rdy=%0b k=%0b eb=%02h want 0 0 1 bc", i, busy, s_ready, enc_k, enc_eb);
            end
        end
    endtask

    task automatic test_retrain();
        int  c = 0;
        bit  done = 1'b0;
        link_en = 1'b0; s_valid = 1'b1; s_data = 8'h42; s_last = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, s_ready, enc_k, enc_eb} !== {3'b001, K_COMMA}) begin
                failures++;
                $display("FAIL retrain_hold[%0d] got busy=%0b rdy=%0b k=%0b eb=%02h want 0 0 1 bc", i, busy, s_ready, enc_k, enc_eb);
            end
        end
        link_en = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (enc_k === 1'b1 && enc_eb === K_COMMA)
                c++;
            else
                done = 1'b1;
        end
        checks++;
        if (c != 16 || !done) begin
            failures++;
            $display("FAIL retrain_commas got %0d want 16", c);
        end
        checks++;
        if ({busy, enc_k, enc_eb} !== {2'b11, K_SOF}) begin
            failures++;
            $display("FAIL retrain_sof got busy=%0b k=%0b eb=%02h want 1 1 fb", busy, enc_k, enc_eb);
        end
        @(negedge clk);
        checks++;
        if ({busy, s_ready, enc_k, enc_eb} !== {3'b100, 8'h42}) begin
            failures++;
            $display("FAIL retrain_byte got busy=%0b rdy=%0b k=%0b eb=%02h want 1 0 0 42", busy, s_ready, enc_k, enc_eb);
        end
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({enc_k, enc_eb} !== {1'b1, K_EOF} || pkt_cnt !== 16'd1) begin
            failures++;
            $display("FAIL retrain_eof got k=%0b eb=%02h pkt=%0d want 1 fd 1", enc_k, enc_eb, pkt_cnt);
        end
    endtask

    task automatic test_packet();
        logic [9:0]  vin [6] = '{{2'b10, 8'hA1}, {2'b10, 8'hA1}, {2'b10, 8'hA2}, {2'b11, 8'hA3}, {2'b00, 8'h00}, {2'b00, 8'h00}};
        logic [10:0] ex  [6] = '{{3'b111, K_SOF}, {3'b110, 8'hA1}, {3'b110, 8'hA2}, {3'b100, 8'hA3}, {3'b101, K_EOF}, {3'b001, K_COMMA}};
        idle(3);
        for (int i = 0; i < 6; i++) begin
            {s_valid, s_last, s_data} = vin[i];
            @(negedge clk);
            checks++;
            if ({busy, s_ready, enc_k, enc_eb} !== ex[i]) begin
                failures++;
                $display("FAIL packet[%0d] got busy/rdy/k/eb=%03h want %03h", i, {busy, s_ready, enc_k, enc_eb}, ex[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 16'd2) begin
            failures++;
            $display("FAIL packet_cnt got %0d want 2", pkt_cnt);
        end
    endtask

    task automatic test_fill();
        logic [9:0]  vin [7] = '{{2'b10, 8'h10}, {2'b10, 8'h10}, {2'b00, 8'h00}, {2'b00, 8'h00}, {2'b11, 8'h20}, {2'b00, 8'h00}, {2'b00, 8'h00}};
        logic [10:0] ex  [7] = '{{3'b111, K_SOF}, {3'b110, 8'h10}, {3'b111, K_FILL}, {3'b111, K_FILL}, {3'b100, 8'h20}, {3'b101, K_EOF}, {3'b001, K_COMMA}};
        idle(3);
        for (int i = 0; i < 7; i++) begin
            {s_valid, s_last, s_data} = vin[i];
            @(negedge clk);
            checks++;
            if ({busy, s_ready, enc_k, enc_eb} !== ex[i]) begin
                failures++;
                $display("FAIL fill[%0d] got busy/rdy/k/eb=%03h want %03h", i, {busy, s_ready, enc_k, enc_eb}, ex[i]);
            end
        end
        checks++;
        if (fill_cnt !== 16'd2 || pkt_cnt !== 16'd3) begin
            failures++;
            $display("FAIL fill_cnt got fill=%0d pkt=%0d want 2 3", fill_cnt, pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  vin [8] = '{{2'b11, 8'h55}, {2'b11, 8'h55}, {2'b11, 8'h66}, {2'b11, 8'h66}, {2'b11, 8'h66}, {2'b11, 8'h66}, {2'b11, 8'h66}, {2'b00, 8'h00}};
        logic [10:0] ex  [8] = '{{3'b111, K_SOF}, {3'b100, 8'h55}, {3'b101, K_EOF}, {3'b001, K_COMMA}, {3'b001, K_COMMA}, {3'b111, K_SOF}, {3'b100, 8'h66}, {3'b101, K_EOF}};
        idle(3);
        for (int i = 0; i < 8; i++) begin
            {s_valid, s_last, s_data} = vin[i];
            @(negedge clk);
            checks++;
            if ({busy, s_ready, enc_k, enc_eb} !== ex[i]) begin
                failures++;
                $display("FAIL b2b[%0d] got busy/rdy/k/eb=%03h want %03h", i, {busy, s_ready, enc_k, enc_eb}, ex[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 16'd5) begin
            failures++;
            $display("FAIL b2b_cnt got %0d want 5", pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        bit done = 1'b0;
        idle(3);
        s_valid = 1'b1; s_data = 8'h77; s_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, s_ready, enc_k, enc_eb} !== {3'b111, K_SOF}) begin
            failures++;
            $display("FAIL mid_sof got k=%0b eb=%02h want 1 fb", enc_k, enc_eb);
        end
        @(negedge clk);
        checks++;
        if ({busy, s_ready, enc_k, enc_eb} !== {3'b110, 8'h77}) begin
            failures++;
            $display("FAIL mid_byte got k=%0b eb=%02h want 0 77", enc_k, enc_eb);
        end
        s_data = 8'h88; reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, s_ready, enc_k, enc_eb} !== {3'b001, K_COMMA} || pkt_cnt !== 16'd0 || fill_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset got busy=%0b rdy=%0b k=%0b eb=%02h pkt=%0d fill=%0d want 0 0 1 bc 0 0", busy, s_ready, enc_k, enc_eb, pkt_cnt, fill_cnt);
        end
        reset = 1'b0; s_data = 8'h99; s_last = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (enc_k === 1'b1 && enc_eb === K_COMMA && s_ready === 1'b0)
                c++;
            else
                done = 1'b1;
        end
        checks++;
        if (c != 16 || !done || enc_eb !== K_SOF) begin
            failures++;
            $display("FAIL mid_realign got %0d commas then eb=%02h want 16 then fb", c, enc_eb);
        end
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({enc_k, enc_eb} !== {1'b1, K_EOF} || pkt_cnt !== 16'd1) begin
            failures++;
            $display("FAIL mid_eof got k=%0b eb=%02h pkt=%0d want 1 fd 1", enc_k, enc_eb, pkt_cnt);
        end
    endtask

    task automatic test_no_skip();
        idle(40);
        checks++;
        if (sk_total != 0) begin
            failures++;
            $display("FAIL no_skip got %0d skip chars want 0", sk_total);
        end
    endtask

    task automatic test_skip();
        logic [10:0] ex [5] = '{{3'b101, K_EOF}, {3'b001, K_COMMA}, {3'b001, K_SKIP}, {3'b001, K_SKIP}, {3'b001, K_COMMA}};
        bit got_sof = 1'b0;
        idle(3);
        s_valid = 1'b1; s_data = 8'h00; s_last = 1'b0;
        for (int i = 0; i < 10 && !got_sof; i++) begin
            @(negedge clk);
            got_sof = (enc_k === 1'b1 && enc_eb === K_SOF);
        end
        checks++;
        if (!got_sof) begin
            failures++;
            $display("FAIL skip_sof got eb=%02h want fb", enc_eb);
        end
        for (int i = 0; i < 40; i++) begin
            s_data = 8'(i);
            s_last = (i == 39);
            @(negedge clk);
            checks++;
            if ({enc_k, enc_eb} !== {1'b0, 8'(i)}) begin
                failures++;
                $display("FAIL skip_data[%0d] got k=%0b eb=%02h want 0 %02h", i, enc_k, enc_eb, 8'(i));
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, s_ready, enc_k, enc_eb} !== ex[i]) begin
                failures++;
                $display("FAIL skip_seq[%0d] got busy/rdy/k/eb=%03h want %03h", i, {busy, s_ready, enc_k, enc_eb}, ex[i]);
            end
        end
        checks++;
        if (sk_in_pkt != 0) begin
            failures++;
            $display("FAIL skip_in_pkt got %0d want 0", sk_in_pkt);
        end
    endtask

    initial begin
        test_reset();
        test_retrain();
`ifdef TX_SKIP_EN
        test_skip();
`else
        test_packet();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        test_no_skip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
